// File: rtl/ulisp_uart.sv
// 8N1 UART on the lisp core register bus: TX FIFO, single-entry RX buffer,
// W1C error flags and a programmable clocks-per-bit divisor.
module ulisp_uart #(
  parameter logic [6:0]  BASE_INDEX      = 7'd0,
  parameter logic [15:0] DEFAULT_DIVISOR = 16'd434,
  parameter int          TX_FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [6:0]  register_index,
  input  logic        register_read,
  input  logic        register_write,
  input  logic [15:0] register_write_value,
  output logic [15:0] register_read_value,
  input  logic        uart_rx,
  output logic        uart_tx
);

  localparam int AW = $clog2(TX_FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(TX_FIFO_DEPTH);

  typedef enum logic [1:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_e;

  logic sel_stat, sel_tx, sel_rx, sel_div;
  assign sel_stat = register_index == BASE_INDEX;
  assign sel_tx   = register_index == BASE_INDEX + 7'd1;
  assign sel_rx   = register_index == BASE_INDEX + 7'd2;
  assign sel_div  = register_index == BASE_INDEX + 7'd3;

  logic [15:0] div_q, div_d, div_eff, div_m1, half_m1;
  logic [15:0] rdata_q, rdata_d;

  // Divisors below 2 would make the mid-start wait negative
  assign div_eff = (div_q < 16'd2) ? 16'd2 : div_q;
  assign div_m1  = div_eff - 16'd1;
  assign half_m1 = (div_eff >> 1) - 16'd1;

  logic [7:0]    mem_q [TX_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push, pop, tx_full, tx_empty;

  assign tx_full  = cnt_q == FULL_CNT;
  assign tx_empty = cnt_q == '0;
  assign push     = register_write & sel_tx & ~tx_full;
  assign cnt_d    = cnt_q + CW'(push) - CW'(pop);

  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        tx_q, tx_d;
  logic        tx_idle;

  assign tx_idle = tx_empty & (tx_state_q == TX_IDLE);
  assign uart_tx = tx_q;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    pop        = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (!tx_empty) begin
          pop        = 1'b1;
          tx_shift_d = mem_q[rd_ptr_q];
          tx_cnt_d   = div_m1;
          tx_state_d = TX_START;
          tx_d       = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt_q == '0) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = div_m1;
          tx_bit_d   = 3'd0;
          tx_d       = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d = div_m1;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
            tx_d       = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_d       = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == '0) begin
          if (!tx_empty) begin
            pop        = 1'b1;
            tx_shift_d = mem_q[rd_ptr_q];
            tx_cnt_d   = div_m1;
            tx_state_d = TX_START;
            tx_d       = 1'b0;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  logic        rx_s1_q, rx_s2_q, rx_prev_q, rx_fall;
  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        rx_valid_q, rx_valid_d;
  logic        ovr_q, ovr_d, ferr_q, ferr_d;
  logic        stop_ok, stop_bad, ovr_set, rx_pop;

  assign rx_fall = rx_prev_q & ~rx_s2_q;
  assign rx_pop  = register_read & sel_rx;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    stop_ok    = 1'b0;
    stop_bad   = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_state_d = RX_START;
          rx_cnt_d   = half_m1;
        end
      end
      RX_START: begin
        if (rx_cnt_q == '0) begin
          if (rx_s2_q) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_DATA;
            rx_cnt_d   = div_m1;
            rx_bit_d   = 3'd0;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_cnt_d   = div_m1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else rx_bit_d = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == '0) begin
          rx_state_d = RX_IDLE;
          stop_ok    = rx_s2_q;
          stop_bad   = ~rx_s2_q;
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // A same-edge RXDATA read frees the buffer for the incoming byte
  always_comb begin
    rx_valid_d = rx_valid_q & ~rx_pop;
    rx_byte_d  = rx_byte_q;
    ovr_set    = 1'b0;
    if (stop_ok) begin
      if (!rx_valid_q || rx_pop) begin
        rx_byte_d  = rx_shift_q;
        rx_valid_d = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end
    ovr_d  = (ovr_q & ~(register_write & sel_stat & register_write_value[3]))
           | ovr_set;
    ferr_d = (ferr_q & ~(register_write & sel_stat & register_write_value[4]))
           | stop_bad;
  end

  always_comb begin
    div_d = div_q;
    if (register_write && sel_div) div_d = register_write_value;
    rdata_d = '0;
    if (register_read) begin
      unique case (1'b1)
        sel_stat: rdata_d = {11'd0, ferr_q, ovr_q, rx_valid_q,
                             tx_idle, tx_full};
        sel_rx:   rdata_d = {rx_valid_q, 7'd0, rx_byte_q};
        sel_div:  rdata_d = div_q;
        default:  rdata_d = '0;
      endcase
    end
  end

  assign register_read_value = rdata_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= register_write_value[7:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
      div_q      <= DEFAULT_DIVISOR;
      rdata_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q      <= cnt_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
      rx_s1_q    <= uart_rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
      ovr_q      <= ovr_d;
      ferr_q     <= ferr_d;
      div_q      <= div_d;
      rdata_q    <= rdata_d;
    end
  end

endmodule

// File: tb/tb_ulisp_uart.sv
// Directed bench for ulisp_uart: reset, TX framing, FIFO overflow,
// RX receive, error flags, glitch rejection and same-edge corner cases.
module tb_ulisp_uart;

  logic        clk;
  logic        reset_n;
  logic [6:0]  register_index;
  logic        register_read;
  logic        register_write;
  logic [15:0] register_write_value;
  logic [15:0] register_read_value;
  logic        uart_rx;
  logic        uart_tx;

  int checks = 0;
  int errors = 0;

  ulisp_uart dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .register_index       (register_index),
    .register_read        (register_read),
    .register_write       (register_write),
    .register_write_value (register_write_value),
    .register_read_value  (register_read_value),
    .uart_rx              (uart_rx),
    .uart_tx              (uart_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic acc(input logic rd, input logic wr, input logic [6:0] idx,
                     input logic [15:0] val, output logic [15:0] rv);
    @(negedge clk);
    register_read        = rd;
    register_write       = wr;
    register_index       = idx;
    register_write_value = val;
    @(negedge clk);
    rv             = register_read_value;
    register_read  = 1'b0;
    register_write = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input int rd_cyc, output logic [15:0] rdv);
    rdv = '0;
    for (int c = 0; c < 96; c++) begin
      @(negedge clk);
      if (c == rd_cyc + 1) rdv = register_read_value;
      if (c < 8)       uart_rx = 1'b0;
      else if (c < 72) uart_rx = b[3'((c - 8) / 8)];
      else if (c < 80) uart_rx = stop;
      else             uart_rx = 1'b1;
      register_read = (c == rd_cyc);
      if (c == rd_cyc) register_index = 7'd2;
    end
    register_read = 1'b0;
  endtask

  logic [15:0] rv;
  logic [9:0]  fr;
  logic [9:0]  got;

  initial begin
    reset_n              = 1'b0;
    register_index       = '0;
    register_read        = 1'b0;
    register_write       = 1'b0;
    register_write_value = '0;
    uart_rx              = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    acc(1, 0, 7'd0, 16'h0, rv); chk("status_after_reset", rv, 16'h0002);
    acc(1, 0, 7'd3, 16'h0, rv); chk("div_after_reset", rv, 16'd434);

    // reset in the middle of a start bit
    acc(0, 1, 7'd3, 16'd7, rv);
    acc(0, 1, 7'd1, 16'h0055, rv);
    repeat (3) @(negedge clk);
    chk("tx_start_low", {15'd0, uart_tx}, 16'h0000);
    #2 reset_n = 1'b0;
    #1 chk("tx_async_reset", {15'd0, uart_tx}, 16'h0001);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    acc(1, 0, 7'd0, 16'h0, rv); chk("status_after_midreset", rv, 16'h0002);
    acc(1, 0, 7'd3, 16'h0, rv); chk("div_after_midreset", rv, 16'd434);

    // single byte, 4 clocks per bit
    acc(0, 1, 7'd3, 16'd4, rv);
    acc(0, 1, 7'd1, 16'h00A5, rv);
    chk("tx_idle_at_write", {15'd0, uart_tx}, 16'h0001);
    fr = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk($sformatf("tx_a5_clk%0d", i), {15'd0, uart_tx},
          {15'd0, fr[i / 4]});
    end
    acc(1, 0, 7'd0, 16'h0, rv); chk("status_after_tx", rv, 16'h0002);

    // overfill the FIFO at 100 clocks per bit
    acc(0, 1, 7'd3, 16'd100, rv);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      register_write       = 1'b1;
      register_index       = 7'd1;
      register_write_value = 16'(i);
    end
    @(negedge clk);
    register_write = 1'b0;
    acc(1, 0, 7'd0, 16'h0, rv); chk("status_full", rv, 16'h0001);
    repeat (39) @(negedge clk);
    for (int k = 0; k < 9; k++) begin
      for (int b = 0; b < 10; b++) begin
        got[b] = uart_tx;
        repeat (100) @(negedge clk);
      end
      chk($sformatf("fifo_frame%0d", k), {6'd0, got},
          {6'd0, 1'b1, 8'(k + 1), 1'b0});
    end
    chk("tx_idle_after_fifo", {15'd0, uart_tx}, 16'h0001);
    acc(1, 0, 7'd0, 16'h0, rv); chk("status_fifo_drained", rv, 16'h0002);

    // receive at 8 clocks per bit
    acc(0, 1, 7'd3, 16'd8, rv);
    send_frame(8'h3C, 1'b1, -1, rv);
    acc(1, 0, 7'd0, 16'h0, rv); chk("status_rx_valid", rv, 16'h0006);
    acc(1, 0, 7'd2, 16'h0, rv); chk("rxdata_first", rv, 16'h803C);
    acc(1, 0, 7'd2, 16'h0, rv); chk("rxdata_second", rv, 16'h003C);
    acc(1, 0, 7'd0, 16'h0, rv); chk("status_rx_popped", rv, 16'h0002);

    send_frame(8'h11, 1'b1, -1, rv);
    send_frame(8'h22, 1'b1, -1, rv);
    acc(1, 0, 7'd0, 16'h0, rv); chk("status_overrun", rv, 16'h000E);
    acc(1, 0, 7'd2, 16'h0, rv); chk("rxdata_kept_first", rv, 16'h8011);

    send_frame(8'h55, 1'b0, -1, rv);
    acc(1, 0, 7'd0, 16'h0, rv); chk("status_framing", rv, 16'h001A);
    acc(1, 0, 7'd2, 16'h0, rv); chk("rxdata_no_load", rv, 16'h0011);
    acc(0, 1, 7'd0, 16'h0018, rv);
    acc(1, 0, 7'd0, 16'h0, rv); chk("status_w1c", rv, 16'h0002);

    // 3-clock glitch must not start a frame
    @(negedge clk); uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    repeat (120) @(negedge clk);
    acc(1, 0, 7'd0, 16'h0, rv); chk("status_glitch", rv, 16'h0002);

    acc(1, 0, 7'd5, 16'h0, rv); chk("read_idx5", rv, 16'h0000);
    acc(1, 0, 7'd1, 16'h0, rv); chk("read_txdata", rv, 16'h0000);

    // stop sample of 0x42 lands on the RXDATA read edge (cycle 78)
    send_frame(8'h41, 1'b1, -1, rv);
    acc(1, 0, 7'd0, 16'h0, rv); chk("status_hold41", rv, 16'h0006);
    send_frame(8'h42, 1'b1, 78, rv);
    chk("rxdata_same_edge", rv, 16'h8041);
    acc(1, 0, 7'd0, 16'h0, rv); chk("status_same_edge", rv, 16'h0006);
    acc(1, 0, 7'd2, 16'h0, rv); chk("rxdata_new_byte", rv, 16'h8042);

    acc(1, 1, 7'd3, 16'h0010, rv); chk("rw_same_cycle_old", rv, 16'h0008);
    acc(1, 0, 7'd3, 16'h0, rv);    chk("rw_same_cycle_new", rv, 16'h0010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
